// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared types and constants for the nRisc fetch path.
package nrisc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
  localparam int NRISC_INSTR_W = 8;
  localparam logic [NRISC_INSTR_W-1:0] NRISC_HALT_OP = 8'hFF;
endpackage

// File: rtl/nrisc_prog_mem.sv
// nrisc_prog_mem: program store with synchronous write and combinational read.
module nrisc_prog_mem #(
  parameter int INSTR_W = 8,
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/nrisc_fetch_sequencer.sv
// nrisc_fetch_sequencer: program store plus pc sequencer presenting one
// instruction per cycle to the core over a valid/ready handshake.
module nrisc_fetch_sequencer
  import nrisc_pkg::*;
#(
  parameter int INSTR_W = NRISC_INSTR_W,
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W = 16,
  parameter bit HALT_EN = 1'b1,
  parameter logic [INSTR_W-1:0] HALT_OP = NRISC_HALT_OP
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W:0]    prog_len,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   retired
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  fetch_state_t state, state_n;
  logic [ADDR_W:0] len_q, pc_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic go, len_ok, xfer, is_halt, redir_ok, bad_redir, stop;
  nrisc_prog_mem #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(CLK),
    .we(prog_we && state != RUN),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  // The read address is the next fetch target, so the new instruction lands
  // in instr on the same edge as the transfer: no bubble on redirects.
  always_comb begin
    go = start && state != RUN;
    len_ok = prog_len != '0 && prog_len <= DEPTH_L;
    xfer = state == RUN && instr_ready;
    pc_inc = {1'b0, pc} + (ADDR_W+1)'(1);
    is_halt = HALT_EN && instr == HALT_OP;
    redir_ok = {1'b0, redirect_pc} < len_q;
    bad_redir = xfer && !is_halt && redirect_valid && !redir_ok;
    stop = xfer && (is_halt || (redirect_valid ? !redir_ok : pc_inc == len_q));
    rd_addr = go ? '0 : redirect_valid ? redirect_pc : pc_inc[ADDR_W-1:0];
  end
  always_ff @(posedge CLK)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = go ? (len_ok ? RUN : HALTED) : stop ? HALTED : state;
  always_comb begin
    busy = state == RUN;
    done = state == HALTED;
    instr_valid = state == RUN;
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      instr <= '0;
      pc <= '0;
      err <= 1'b0;
      retired <= '0;
      len_q <= '0;
    end else if (go) begin
      err <= !len_ok;
      if (len_ok) begin
        len_q <= prog_len;
        retired <= '0;
        instr <= rd_data;
        pc <= '0;
      end
    end else if (xfer) begin
      if (retired != '1) retired <= retired + CNT_W'(1);
      if (bad_redir) err <= 1'b1;
      if (!stop) begin
        instr <= rd_data;
        pc <= rd_addr;
      end
    end
endmodule

// File: tb/tb_nrisc_fetch_sequencer.sv
// tb_nrisc_fetch_sequencer: table-driven cycle vectors plus directed corner sequences.
module tb_nrisc_fetch_sequencer;
  logic CLK = 1'b0, RESET = 1'b1, start = 1'b0, prog_we = 1'b0;
  logic instr_ready = 1'b0, redirect_valid = 1'b0;
  logic [4:0] prog_addr = '0, redirect_pc = '0;
  logic [7:0] prog_data = '0;
  logic [5:0] prog_len = '0;
  logic [7:0] instr;
  logic [4:0] pc;
  logic instr_valid, busy, done, err;
  logic [15:0] retired;
  int checks = 0, failures = 0;

  typedef struct {
    logic st;
    logic [5:0] len;
    logic rdy, rv;
    logic [4:0] rpc;
    logic [32:0] exp;
  } vec_t;
  vec_t tbl[$];

  nrisc_fetch_sequencer dut (
    .CLK(CLK), .RESET(RESET), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_len(prog_len),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .done(done), .err(err), .retired(retired)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [7:0] img(int a);
    return a == 0 ? 8'h01 : a <= 3 ? 8'h09 : 8'(32'h20 + a);
  endfunction

  // {busy, valid, instr, pc, done, err, retired}
  function automatic logic [32:0] ex(int v, int ins, int p, int dn, int er, int ret);
    return {1'(v), 1'(v), 8'(ins), 5'(p), 1'(dn), 1'(er), 16'(ret)};
  endfunction

  function automatic logic [32:0] obs();
    return {busy, instr_valid, instr, pc, done, err, retired};
  endfunction

  task automatic add(int st, int len, int rdy, int rv, int rpc, logic [32:0] e);
    tbl.push_back('{1'(st), 6'(len), 1'(rdy), 1'(rv), 5'(rpc), e});
  endtask

  task automatic chk(string n, logic [32:0] a, logic [32:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_start(int len);
    start = 1'b1;
    prog_len = 6'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic run_to_done(int lim);
    int n = 0;
    while (!done && n < lim) begin
      cyc();
      n++;
    end
    chk("run_to_done", {32'b0, done}, 33'd1);
  endtask

  initial begin
    cyc();
    cyc();
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) begin
      prog_we = 1'b1;
      prog_addr = 5'(i);
      prog_data = img(i);
      cyc();
    end
    prog_we = 1'b0;
    // straight-line run of four
    add(1, 4, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    for (int p = 0; p < 4; p++) add(0, 0, 1, 0, 0, ex(1, img(p), p, 0, 0, p));
    add(0, 0, 1, 0, 0, ex(0, 8'h09, 3, 1, 0, 4));
    // stall at pc 2 with a redirect offered but no transfer
    add(1, 4, 1, 0, 0, ex(0, 8'h09, 3, 1, 0, 4));
    add(0, 0, 1, 0, 0, ex(1, 8'h01, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, ex(1, 8'h09, 1, 0, 0, 1));
    for (int s = 0; s < 3; s++) add(0, 0, 0, 1, 0, ex(1, 8'h09, 2, 0, 0, 2));
    add(0, 0, 1, 0, 0, ex(1, 8'h09, 2, 0, 0, 2));
    add(0, 0, 1, 0, 0, ex(1, 8'h09, 3, 0, 0, 3));
    add(0, 0, 0, 0, 0, ex(0, 8'h09, 3, 1, 0, 4));
    // loop 6..12 via redirect, three passes, no bubbles
    add(1, 13, 0, 0, 0, ex(0, 8'h09, 3, 1, 0, 4));
    for (int p = 0; p < 13; p++) add(0, 0, 1, int'(p == 12), 6, ex(1, img(p), p, 0, 0, p));
    for (int k = 1; k <= 2; k++)
      for (int p = 6; p <= 12; p++)
        add(0, 0, 1, int'(k == 1 && p == 12), 6, ex(1, img(p), p, 0, 0, 13 + 7 * (k - 1) + p - 6));
    add(0, 0, 0, 0, 0, ex(0, img(12), 12, 1, 0, 27));
    foreach (tbl[i]) begin
      chk($sformatf("row%0d", i), obs(), tbl[i].exp);
      start = tbl[i].st;
      prog_len = tbl[i].len;
      instr_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      cyc();
    end
    start = 1'b0;
    redirect_valid = 1'b0;
    // halt opcode at pc 5, with and without a competing redirect
    prog_we = 1'b1;
    prog_addr = 5'd5;
    prog_data = 8'hFF;
    cyc();
    prog_we = 1'b0;
    instr_ready = 1'b1;
    do_start(10);
    run_to_done(40);
    chk("halt_op", obs(), ex(0, 8'hFF, 5, 1, 0, 6));
    do_start(10);
    begin
      int n = 0;
      redirect_pc = 5'd0;
      while (!done && n < 40) begin
        redirect_valid = pc == 5'd5;
        cyc();
        n++;
      end
    end
    redirect_valid = 1'b0;
    chk("halt_over_redirect", obs(), ex(0, 8'hFF, 5, 1, 0, 6));
    // illegal redirect, bad lengths, err clearing, full-depth program
    prog_we = 1'b1;
    prog_data = 8'h25;
    cyc();
    prog_we = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 5'd12;
    do_start(10);
    cyc();
    redirect_valid = 1'b0;
    chk("bad_redirect", obs(), ex(0, 8'h01, 0, 1, 1, 1));
    do_start(0);
    chk("len0", obs(), ex(0, 8'h01, 0, 1, 1, 1));
    do_start(4);
    chk("restart_clears_err", obs(), ex(1, 8'h01, 0, 0, 0, 0));
    run_to_done(10);
    chk("len4_done", obs(), ex(0, 8'h09, 3, 1, 0, 4));
    do_start(33);
    chk("len33", obs(), ex(0, 8'h09, 3, 1, 1, 4));
    do_start(32);
    run_to_done(40);
    chk("len32_done", obs(), ex(0, 8'h3F, 31, 1, 0, 32));
    // reset mid-run, then write attempts during RUN
    do_start(10);
    begin
      int n = 0;
      while (pc != 5'd4 && n < 20) begin
        cyc();
        n++;
      end
    end
    chk("reach_pc4", {28'b0, pc}, 33'd4);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("mid_reset", obs(), ex(0, 0, 0, 0, 0, 0));
    do_start(4);
    chk("replay_pc0", obs(), ex(1, 8'h01, 0, 0, 0, 0));
    prog_we = 1'b1;
    prog_addr = 5'd3;
    prog_data = 8'h77;
    cyc();
    chk("replay_pc1", obs(), ex(1, 8'h09, 1, 0, 0, 1));
    cyc();
    prog_we = 1'b0;
    chk("replay_pc2", obs(), ex(1, 8'h09, 2, 0, 0, 2));
    cyc();
    chk("run_write_ignored", obs(), ex(1, 8'h09, 3, 0, 0, 3));
    cyc();
    chk("replay_done", obs(), ex(0, 8'h09, 3, 1, 0, 4));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nrisc_fetch_sequencer.md
Name: nrisc_fetch_sequencer

Overview:
Parametrised instruction store and program-counter sequencer that feeds the nRisc core. It replaces the free-running, counter-indexed instruction array with a real fetch unit. It adds:
- a loadable program memory
- a valid/ready handshake to the core
- branch redirect, so loops run without unrolled copies
- program-length and halt-opcode termination, plus a retired-instruction count

It sits between the testbench or loader and the core's instruction input.

Parameters:
INSTR_W, 8, instruction width in bits
DEPTH, 32, program memory entries
ADDR_W, $clog2(DEPTH), pc/address width
CNT_W, 16, retired-instruction counter width
HALT_EN, 1, 1 = transferring HALT_OP terminates the program
HALT_OP, 8'hFF, halt opcode (INSTR_W bits)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  begin execution at pc 0 (IDLE or HALTED only)
prog_we  in  1  program memory write enable
prog_addr  in  ADDR_W  write address
prog_data  in  INSTR_W  write data
prog_len  in  ADDR_W+1  number of valid instructions (1..DEPTH); sampled on start
instr  out  INSTR_W  current instruction to core
instr_valid  out  1  instr/pc valid
instr_ready  in  1  core accepts instr this cycle
pc  out  ADDR_W  address of the current instr
redirect_valid  in  1  branch taken, qualified by transfer
redirect_pc  in  ADDR_W  branch target
busy  out  1  state == RUN
done  out  1  state == HALTED
err  out  1  sticky: illegal redirect or bad prog_len
retired  out  CNT_W  count of transferred instructions, saturating

Behaviour:
- States: IDLE, RUN, HALTED. RESET (any state, mid-run included) -> IDLE.
- Reset values: instr=0, instr_valid=0, pc=0, busy=0, done=0, err=0, retired=0, len_q=0. Memory contents are NOT reset.
- Memory: synchronous write. prog_we is honoured only in IDLE/HALTED and ignored in RUN. A write to the address being fetched the same cycle does not affect that fetch.
- start in IDLE/HALTED:
  - If prog_len == 0 or prog_len > DEPTH -> HALTED, err=1.
  - Otherwise len_q<=prog_len, retired<=0, err<=0, state RUN.
  - Next edge: instr=mem[0], pc=0, instr_valid=1. Start-to-valid latency is 1 cycle.
- start in RUN is ignored.
- Transfer = instr_valid && instr_ready. With no transfer, instr/pc/instr_valid hold stable; redirect inputs are ignored.
- On transfer, retired += 1 (saturates at 2^CNT_W-1). Next target, in priority order:
  1. HALT_EN && instr == HALT_OP -> HALTED (redirect ignored).
  2. redirect_valid: if redirect_pc < len_q, fetch redirect_pc; else HALTED, err=1.
  3. pc+1 == len_q -> HALTED.
  4. Otherwise fetch pc+1.
- Back-to-back: a new instr is presented the cycle after a transfer. Sustained throughput is 1 instr/cycle with instr_ready held high, including across redirects (no bubble).
- HALTED: instr_valid=0, done=1. instr/pc retain the last transferred values and retired is held.
- pc never wraps. The sequence ends at len_q; it does not roll over at DEPTH.

Decomposition:
- Package nrisc_pkg: fetch_state_t enum (IDLE, RUN, HALTED), NRISC_INSTR_W=8, NRISC_HALT_OP.
- One sub-module, nrisc_prog_mem: DEPTH x INSTR_W, sync write, combinational read. The sequencer registers the read into instr.

Test Plan:
1. Load mem[0..3]=01,09,09,09 with prog_len=4, pulse start, instr_ready=1 -> instr 01,09,09,09 at pc 0..3 on consecutive cycles, then done=1, retired=4, err=0.
2. instr_ready low for 3 cycles while pc=2 -> instr/pc held; retired does not increment; resumes with pc=3 after ready rises.
3. Program length 13. redirect_valid=1, redirect_pc=6 on transfer at pc=12, twice, then none -> pc sequence is 6..12 three times with no bubbles, done=1, retired=27 (6+7+7+7).
4. mem[5]=FF with HALT_EN=1, prog_len=10 -> halts after pc=5 transfers, retired=6, done=1. Same transfer with redirect_valid=1 -> still halts.
5. redirect_pc=12 with len_q=10 -> done=1, err=1. start with prog_len=0 -> done=1, err=1. A following valid start clears err.
6. RESET asserted mid-run at pc=4 -> next cycle IDLE with all outputs at reset values. prog_we during RUN leaves memory unchanged. start after reset replays the program from mem[0].
